// File: rtl/fitbit_display_scheduler.sv
// Once-per-second timebase and rotating display-slot scheduler for the tracker.
// Produces sec_tick, a legacy divided slowclk, the active slot and a saturating seconds count.
module fitbit_display_scheduler #(
  parameter int unsigned DIV     = 100000000,
  parameter int unsigned SLOTS   = 4,
  parameter int unsigned DWELL_S = 2,
  parameter int unsigned SW      = 4
) (
  input  logic          otherclk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          hold,
  input  logic          advance,
  input  logic          clr_count,
  output logic          sec_tick,
  output logic          slowclk,
  output logic [SW-1:0] slot,
  output logic          slot_change,
  output logic [15:0]   sec_count
);

  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DWW = $clog2(DWELL_S + 1);

  localparam logic [PW-1:0]  PRE_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0]  PRE_HALF   = PW'(DIV / 2 - 1);
  localparam logic [SW-1:0]  SLOT_LAST  = SW'(SLOTS - 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_S - 1);
  localparam logic [15:0]    CNT_MAX    = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [PW-1:0]  pre, pre_n;
  logic [DWW-1:0] dwell, dwell_n;
  logic [SW-1:0]  slot_n, slot_next;
  logic           sec_tick_n, slowclk_n, slot_change_n;
  logic [15:0]    sec_count_n;
  logic           running, step;

  // State and registered outputs
  always_ff @(posedge otherclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pre         <= '0;
      dwell       <= '0;
      sec_tick    <= 1'b0;
      slowclk     <= 1'b0;
      slot        <= '0;
      slot_change <= 1'b0;
      sec_count   <= '0;
    end else begin
      state       <= state_n;
      pre         <= pre_n;
      dwell       <= dwell_n;
      sec_tick    <= sec_tick_n;
      slowclk     <= slowclk_n;
      slot        <= slot_n;
      slot_change <= slot_change_n;
      sec_count   <= sec_count_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    pre_n         = pre;
    dwell_n       = dwell;
    slot_n        = slot;
    sec_tick_n    = 1'b0;
    slowclk_n     = slowclk;
    slot_change_n = 1'b0;
    sec_count_n   = sec_count;
    running       = (state == RUN) || (state == HOLD);
    step          = 1'b0;
    slot_next     = (slot == SLOT_LAST) ? '0 : slot + SW'(1);

    case (state)
      IDLE:    if (enable) state_n = RUN;
      RUN:     if (!enable) state_n = IDLE; else if (hold) state_n = HOLD;
      HOLD:    if (!enable) state_n = IDLE; else if (!hold) state_n = RUN;
      default: state_n = IDLE;
    endcase

    // The tick seen here is the registered one, so counting lags the strobe by a cycle
    if (clr_count) begin
      sec_count_n = '0;
    end else if (running && sec_tick && (sec_count != CNT_MAX)) begin
      sec_count_n = sec_count + 16'd1;
    end

    if (running && enable) begin
      pre_n      = (pre == PRE_LAST) ? '0 : pre + PW'(1);
      sec_tick_n = (pre == PRE_LAST);
      if ((pre == PRE_HALF) || (pre == PRE_LAST)) begin
        slowclk_n = ~slowclk;
      end

      // Manual advance and dwell expiry merge into a single one-slot step
      step = advance || ((state == RUN) && sec_tick && (dwell == DWELL_LAST));
      if (step) begin
        slot_n        = slot_next;
        dwell_n       = '0;
        slot_change_n = 1'b1;
      end else if ((state == RUN) && sec_tick) begin
        dwell_n = dwell + DWW'(1);
      end
    end else begin
      pre_n     = '0;
      dwell_n   = '0;
      slowclk_n = 1'b0;
      slot_n    = '0;
    end
  end

endmodule

// File: tb/tb_fitbit_display_scheduler.sv
// Self-checking bench for fitbit_display_scheduler with DIV=4, SLOTS=4, DWELL_S=2.
// Expected slots are queued when stimulus is driven and popped on every slot_change.
module tb_fitbit_display_scheduler;

  localparam int unsigned DIV     = 4;
  localparam int unsigned SLOTS   = 4;
  localparam int unsigned DWELL_S = 2;
  localparam int unsigned SW      = 4;

  logic          otherclk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          hold;
  logic          advance;
  logic          clr_count;
  logic          sec_tick;
  logic          slowclk;
  logic [SW-1:0] slot;
  logic          slot_change;
  logic [15:0]   sec_count;

  int            total = 0;
  int            bad   = 0;
  int            ncyc  = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] mon_exp;

  fitbit_display_scheduler #(
    .DIV(DIV), .SLOTS(SLOTS), .DWELL_S(DWELL_S), .SW(SW)
  ) dut (
    .otherclk(otherclk), .rst_n(rst_n), .enable(enable), .hold(hold),
    .advance(advance), .clr_count(clr_count), .sec_tick(sec_tick),
    .slowclk(slowclk), .slot(slot), .slot_change(slot_change),
    .sec_count(sec_count)
  );

  always #5 otherclk = ~otherclk;

  // Scoreboard: every slot_change must match the next queued slot
  always @(negedge otherclk) begin
    if (rst_n && slot_change) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_change: got slot=%0d, required no slot_change", slot);
      end else begin
        mon_exp = exp_q.pop_front();
        if (slot !== mon_exp) begin
          bad++;
          $display("FAIL sb_slot: got %0d required %0d", slot, mon_exp);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge otherclk);
    ncyc += n;
  endtask

  task automatic run_to(input int k);
    if (k > ncyc) step(k - ncyc);
  endtask

  task automatic do_reset();
    @(negedge otherclk);
    rst_n = 1'b0; enable = 1'b0; hold = 1'b0; advance = 1'b0; clr_count = 1'b0;
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic start();
    enable = 1'b1;
    ncyc   = 0;
  endtask

  task automatic test_reset();
    @(negedge otherclk);
    rst_n = 1'b0; enable = 1'b0; hold = 1'b0; advance = 1'b0; clr_count = 1'b0;
    step(2);
    total++; if (sec_tick !== 1'b0) begin bad++; $display("FAIL rst_sec_tick: got %0b required 0", sec_tick); end
    total++; if (slowclk !== 1'b0) begin bad++; $display("FAIL rst_slowclk: got %0b required 0", slowclk); end
    total++; if (slot !== '0) begin bad++; $display("FAIL rst_slot: got %0d required 0", slot); end
    total++; if (slot_change !== 1'b0) begin bad++; $display("FAIL rst_slot_change: got %0b required 0", slot_change); end
    total++; if (sec_count !== 16'd0) begin bad++; $display("FAIL rst_sec_count: got %0d required 0", sec_count); end
    rst_n = 1'b1;
    step(4);
    total++; if (sec_tick !== 1'b0) begin bad++; $display("FAIL idle_no_tick: got %0b required 0", sec_tick); end
  endtask

  task automatic test_timebase();
    logic e_tick, e_slow;
    do_reset();
    start();
    exp_q.push_back(SW'(1));
    exp_q.push_back(SW'(2));
    for (int k = 1; k <= 20; k++) begin
      step(1);
      e_tick = (k >= 5) && (k % 4 == 1);
      e_slow = (((k - 1) >> 1) & 1) == 1;
      total++; if (sec_tick !== e_tick) begin bad++; $display("FAIL tb_sec_tick@%0d: got %0b required %0b", k, sec_tick, e_tick); end
      total++; if (slowclk !== e_slow) begin bad++; $display("FAIL tb_slowclk@%0d: got %0b required %0b", k, slowclk, e_slow); end
      if (k == 9) begin
        total++; if (slot !== SW'(0)) begin bad++; $display("FAIL tb_slot_before: got %0d required 0", slot); end
      end
    end
    total++; if (sec_count !== 16'd4) begin bad++; $display("FAIL tb_sec_count: got %0d required 4", sec_count); end
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL tb_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_rotation();
    logic [SW-1:0] seq [8];
    seq = '{SW'(1), SW'(2), SW'(3), SW'(0), SW'(1), SW'(2), SW'(3), SW'(0)};
    do_reset();
    start();
    for (int i = 0; i < 8; i++) exp_q.push_back(seq[i]);
    run_to(65);
    total++; if (slot !== SW'(3)) begin bad++; $display("FAIL rot_before_wrap: got %0d required 3", slot); end
    run_to(68);
    total++; if (slot !== SW'(0)) begin bad++; $display("FAIL rot_final: got %0d required 0", slot); end
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rot_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_hold();
    do_reset();
    start();
    exp_q.push_back(SW'(1));
    run_to(14);
    total++; if (sec_count !== 16'd3) begin bad++; $display("FAIL hold_pre_count: got %0d required 3", sec_count); end
    hold = 1'b1;
    run_to(53);
    total++; if (sec_tick !== 1'b1) begin bad++; $display("FAIL hold_tick_runs: got %0b required 1", sec_tick); end
    run_to(54);
    total++; if (sec_count !== 16'd13) begin bad++; $display("FAIL hold_count: got %0d required 13", sec_count); end
    total++; if (slot !== SW'(1)) begin bad++; $display("FAIL hold_slot: got %0d required 1", slot); end
    hold = 1'b0;
    exp_q.push_back(SW'(2));
    run_to(57);
    total++; if (slot !== SW'(1)) begin bad++; $display("FAIL hold_resume_early: got %0d required 1", slot); end
    run_to(58);
    total++; if (slot !== SW'(2)) begin bad++; $display("FAIL hold_resume: got %0d required 2", slot); end
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL hold_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_advance();
    do_reset();
    start();
    exp_q.push_back(SW'(1));
    run_to(9);
    total++; if (sec_tick !== 1'b1) begin bad++; $display("FAIL adv_coincident_tick: got %0b required 1", sec_tick); end
    advance = 1'b1;
    step(1);
    advance = 1'b0;
    total++; if (slot !== SW'(1)) begin bad++; $display("FAIL adv_expiry_slot: got %0d required 1", slot); end
    exp_q.push_back(SW'(2));
    run_to(12);
    total++; if (slot !== SW'(1)) begin bad++; $display("FAIL adv_single_step: got %0d required 1", slot); end
    run_to(20);
    total++; if (slot !== SW'(2)) begin bad++; $display("FAIL adv_dwell_after: got %0d required 2", slot); end
    // Back-to-back pulses
    advance = 1'b1;
    exp_q.push_back(SW'(3));
    exp_q.push_back(SW'(0));
    step(1);
    total++; if (slot_change !== 1'b1) begin bad++; $display("FAIL b2b_change1: got %0b required 1", slot_change); end
    total++; if (sec_tick !== 1'b1) begin bad++; $display("FAIL b2b_prescaler: got %0b required 1", sec_tick); end
    step(1);
    advance = 1'b0;
    total++; if (slot_change !== 1'b1) begin bad++; $display("FAIL b2b_change2: got %0b required 1", slot_change); end
    total++; if (slot !== SW'(0)) begin bad++; $display("FAIL b2b_slot: got %0d required 0", slot); end
    step(1);
    total++; if (slot_change !== 1'b0) begin bad++; $display("FAIL b2b_change_end: got %0b required 0", slot_change); end
    // Advance with enable falling, then advance in IDLE
    run_to(24);
    enable = 1'b0; advance = 1'b1;
    step(1);
    advance = 1'b0;
    total++; if (slot !== SW'(0)) begin bad++; $display("FAIL adv_idle_wins: got %0d required 0", slot); end
    advance = 1'b1;
    step(1);
    advance = 1'b0;
    step(1);
    total++; if (slot !== SW'(0)) begin bad++; $display("FAIL adv_in_idle: got %0d required 0", slot); end
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL adv_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    do_reset();
    start();
    exp_q.push_back(SW'(1));
    exp_q.push_back(SW'(2));
    exp_q.push_back(SW'(3));
    run_to(4);
    force dut.sec_count = 16'hFFFD;
    #1;
    release dut.sec_count;
    run_to(8);
    total++; if (sec_count !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe: got %0h required fffe", sec_count); end
    run_to(12);
    total++; if (sec_count !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff: got %0h required ffff", sec_count); end
    run_to(20);
    total++; if (sec_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %0h required ffff", sec_count); end
    run_to(21);
    total++; if (sec_tick !== 1'b1) begin bad++; $display("FAIL clr_coincident_tick: got %0b required 1", sec_tick); end
    clr_count = 1'b1;
    step(1);
    clr_count = 1'b0;
    total++; if (sec_count !== 16'd0) begin bad++; $display("FAIL clr_priority: got %0h required 0", sec_count); end
    run_to(26);
    total++; if (sec_count !== 16'd1) begin bad++; $display("FAIL clr_resume: got %0h required 1", sec_count); end
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sat_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start();
    exp_q.push_back(SW'(1));
    exp_q.push_back(SW'(2));
    run_to(19);
    total++; if (slot !== SW'(2)) begin bad++; $display("FAIL arst_pre_slot: got %0d required 2", slot); end
    total++; if (slowclk !== 1'b1) begin bad++; $display("FAIL arst_pre_slowclk: got %0b required 1", slowclk); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (slot !== SW'(0)) begin bad++; $display("FAIL arst_slot: got %0d required 0", slot); end
    total++; if (slowclk !== 1'b0) begin bad++; $display("FAIL arst_slowclk: got %0b required 0", slowclk); end
    total++; if (sec_count !== 16'd0) begin bad++; $display("FAIL arst_sec_count: got %0d required 0", sec_count); end
    total++; if (sec_tick !== 1'b0) begin bad++; $display("FAIL arst_sec_tick: got %0b required 0", sec_tick); end
    total++; if (slot_change !== 1'b0) begin bad++; $display("FAIL arst_slot_change: got %0b required 0", slot_change); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL arst_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_idle();
    do_reset();
    start();
    exp_q.push_back(SW'(1));
    exp_q.push_back(SW'(2));
    run_to(20);
    enable = 1'b0;
    step(1);
    total++; if (slot !== SW'(0)) begin bad++; $display("FAIL idle_slot: got %0d required 0", slot); end
    total++; if (slowclk !== 1'b0) begin bad++; $display("FAIL idle_slowclk: got %0b required 0", slowclk); end
    total++; if (sec_count !== 16'd4) begin bad++; $display("FAIL idle_count_kept: got %0d required 4", sec_count); end
    total++; if (slot_change !== 1'b0) begin bad++; $display("FAIL idle_no_change: got %0b required 0", slot_change); end
    for (int i = 0; i < 8; i++) begin
      step(1);
      total++; if (sec_tick !== 1'b0) begin bad++; $display("FAIL idle_tick@%0d: got %0b required 0", i, sec_tick); end
    end
    total++; if (sec_count !== 16'd4) begin bad++; $display("FAIL idle_count_still: got %0d required 4", sec_count); end
    // Re-enable: prescaler restarts from zero
    start();
    run_to(4);
    total++; if (sec_tick !== 1'b0) begin bad++; $display("FAIL reen_early: got %0b required 0", sec_tick); end
    run_to(5);
    total++; if (sec_tick !== 1'b1) begin bad++; $display("FAIL reen_tick: got %0b required 1", sec_tick); end
    run_to(6);
    total++; if (sec_count !== 16'd5) begin bad++; $display("FAIL reen_count: got %0d required 5", sec_count); end
    #1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL idle_drain: got %0d pending required 0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; hold = 1'b0; advance = 1'b0; clr_count = 1'b0;
    test_reset();
    test_timebase();
    test_rotation();
    test_hold();
    test_advance();
    test_saturation();
    test_async_reset();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
